// File: rtl/data_memo_pkg.sv
// data_memo_pkg: shared defaults, stack-op encoding and width helper for the data/stack memory.
package data_memo_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int MEM_DEPTH_DEF = 512;
  localparam int STACK_DEPTH_DEF = 512;
  typedef enum logic [1:0] {NONE, PUSH, POP, REPLACE} stackOp_t;
  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/data_stack_memory_lifo_stack.sv
// lifo_stack: hardware LIFO with registered top, occupancy flags and sticky overflow/underflow.
module lifo_stack import data_memo_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF,
  parameter int CNT_W = cntWidth(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              errClr,
  input  logic [DATA_W-1:0] pushData,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);
  localparam int IW = $clog2(DEPTH);
  logic [DATA_W-1:0] entries [DEPTH];
  stackOp_t op;
  logic doPush, doPop, doWrite;
  logic [CNT_W-1:0] nextCount, wrIdx, rdIdx;
  always_comb begin
    op = push && pop && !empty ? REPLACE : push ? PUSH : pop ? POP : NONE;
    doPush = op == PUSH && !full;
    doPop = op == POP && !empty;
    doWrite = doPush || op == REPLACE;
    wrIdx = op == REPLACE ? count - CNT_W'(1) : count;
    rdIdx = count - CNT_W'(2);
    nextCount = doPush ? count + CNT_W'(1) : doPop ? count - CNT_W'(1) : count;
  end
  always_ff @(posedge clk)
    if (doWrite) entries[wrIdx[IW-1:0]] <= pushData;
  // The new top after a pop is read from the entry below the current top.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      top <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      top <= doWrite ? pushData : doPop ? (count == CNT_W'(1) ? {DATA_W{1'b0}} : entries[rdIdx[IW-1:0]]) : top;
      count <= nextCount;
      empty <= nextCount == '0;
      full <= nextCount == CNT_W'(DEPTH);
      overflow <= (op == PUSH && full) || (overflow && !errClr);
      underflow <= (op == POP && empty) || (underflow && !errClr);
    end
endmodule

// File: rtl/data_stack_memory.sv
// data_stack_memory: static data RAM with registered load plus an independent hardware stack.
module data_stack_memory import data_memo_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_W = 32,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int CNT_W = cntWidth(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] stack_top,
  output logic [CNT_W-1:0]  stack_count,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              overflow,
  output logic              underflow,
  output logic              addr_err
);
  localparam int MW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MEM_DEPTH);
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic inRange;
  logic [MW-1:0] idx;
  // Range check on the full address so high addresses never alias into the RAM.
  assign inRange = {1'b0, addr} < LIMIT;
  assign idx = addr[MW-1:0];
  always_ff @(posedge clk)
    if (mem_wr && inRange) mem[idx] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= mem_rd && inRange;
      if (mem_rd && inRange) rd_data <= mem[idx];
      addr_err <= ((mem_rd || mem_wr) && !inRange) || (addr_err && !err_clr);
    end
  lifo_stack #(.DATA_W(DATA_W), .DEPTH(STACK_DEPTH), .CNT_W(CNT_W)) stack (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .errClr(err_clr),
    .pushData(push_data),
    .top(stack_top),
    .count(stack_count),
    .empty(stack_empty),
    .full(stack_full),
    .overflow(overflow),
    .underflow(underflow)
  );
endmodule
